uart_rx_fifo: RTL and testbench
===============================

# uart_rx_fifo

Receive buffer between the `uartRX` byte receiver and the CPU data path. It turns the receiver's `valid` level into single-cycle pushes on the rising edge and stores bytes in a synchronous FIFO. It presents the head byte zero-extended to 32 bits, plus a 32-bit status word, so software can poll and pop received bytes without losing characters that arrive between instructions.

## Interface
- `DEPTH`, 16: FIFO entries; power of two, 2..128.
- `clk`  in  1: clock, all state on rising edge.
- `rst`  in  1: reset, asynchronous, active-high.
- `rx_data`  in  8: byte from `uartRX`, stable while `rx_valid`=1.
- `rx_valid`  in  1: level from `uartRX`, synchronous to `clk`, may stay high several cycles per byte.
- `pop`  in  1: remove head entry this cycle; single-cycle strobe from CPU read of data register.
- `clr_overrun`  in  1: clear sticky overrun flag.
- `rd_data`  out  32: `{24'b0, head}`; 32'h0 when empty.
- `status`  out  32: [7:0] count, [8] empty, [9] full, [10] overrun, [31:11] zero.
- `empty`  out  1: count==0.
- `full`  out  1: count==DEPTH.

## Operation
- Edge detect: `rx_prev` register tracks `rx_valid`. `push` = `rx_valid & ~rx_prev`. Exactly one push per `valid` pulse, regardless of pulse length.
- Storage: DEPTH×8 array, write pointer `wp` and read pointer `rp` of log2(DEPTH) bits, wrapping modulo DEPTH. `count` is log2(DEPTH)+1 bits.
- Push, not full: `mem[wp]<=rx_data`, `wp++`, `count++`.
- Push, full, no pop: byte dropped. `overrun<=1`. Pointers and count unchanged.
- Push and pop, full: both occur, count stays DEPTH, no overrun.
- Push and pop, empty: push only. Pop ignored, count becomes 1. No bypass.
- Push and pop, otherwise: both occur, count unchanged.
- Pop, empty, no push: ignored, no error flag.
- Pop, not empty: `rp++`, `count--`.
- Overrun is sticky. `clr_overrun` clears it. If `clr_overrun` coincides with a dropping push, overrun ends set (set wins).
- `rd_data`/`head` = `mem[rp]`, show-ahead (combinational read of registered array, gated to 0 when empty).
- No state machine beyond pointers/count/flags. Overflow/underflow of counters must be impossible by construction.

## Timing
- Reset values: `wp`=`rp`=0, `count`=0, `overrun`=0, `rx_prev`=1, `rd_data`=0, `status`=32'h0000_0100, `empty`=1, `full`=0.
- `rx_prev` resets to 1 so a `rx_valid` held high across reset release is not captured.
- Push latency: byte written at the first rising edge where `rx_valid`=1 and `rx_prev`=0. `empty`, `count` and `rd_data` reflect it immediately after that edge (1 cycle).
- Pop latency: pop sampled at edge k. The next entry appears on `rd_data` after edge k. The CPU reads `rd_data` before issuing `pop` in the same access.
- Reset mid-operation: all contents discarded immediately (async). The next byte is accepted only after `rx_valid` is seen low then high.
- All outputs derive from registers plus combinational decode. No combinational path from `pop`/`rx_valid` to outputs.

## Structure
- Shared package `uart_pkg`:
  - `UART_FIFO_DEPTH` default.
  - Status bit indices `ST_EMPTY`=8, `ST_FULL`=9, `ST_OVR`=10.
  - `ST_COUNT_MSB`=7.
- One sub-module is natural: `byte_fifo` (generic sync FIFO: push/pop/data/count/full/empty).
- `uart_rx_fifo` wraps `byte_fifo` and adds edge detect, overrun logic and status/data word formatting.

## Test plan
- Reset, then `rx_valid` held high through reset release with `rx_data`=8'h55 → no push; `status`=32'h100, `rd_data`=0.
- Send 8'h44 with `rx_valid` high 5 cycles → exactly one push; `count`=1, `rd_data`=32'h44. Then `pop` → `empty`=1, `rd_data`=0.
- Push 16 bytes 8'h00..8'h0F, then a 17th byte 8'h4C → `full`=1, `status`[10]=1. Pop 16 → sequence 00..0F, byte 4C never appears. Then `clr_overrun` → bit 10=0.
- Full FIFO, push 8'h52 with simultaneous pop → count stays 16, no overrun, 8'h52 emerges last. Wrap-around order correct after 40 mixed push/pop operations vs. reference queue model.
- Empty FIFO, push 8'hAA and pop same cycle → `count`=1, `rd_data`=32'hAA. Pop on empty with no push → no change.
- Assert `rst` with 5 entries and overrun set → next cycle `status`=32'h100, pointers 0. A following byte is stored at entry 0.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared constants and the status-word formatter for the UART receive path.
package uart_pkg;

  localparam int UART_FIFO_DEPTH = 16;

  // Bit positions inside the 32-bit status word.
  localparam int ST_COUNT_MSB = 7;
  localparam int ST_EMPTY     = 8;
  localparam int ST_FULL      = 9;
  localparam int ST_OVR       = 10;

  // Pack count and flags into the software-visible status word; unused bits read 0.
  function automatic logic [31:0] fmt_status(input logic [7:0] cnt, input logic emp,
                                             input logic ful, input logic ovr);
    logic [31:0] st;
    st                  = '0;
    st[ST_COUNT_MSB:0]  = cnt;
    st[ST_EMPTY]        = emp;
    st[ST_FULL]         = ful;
    st[ST_OVR]          = ovr;
    return st;
  endfunction

endpackage

// File: rtl/byte_fifo.sv
// Generic synchronous show-ahead FIFO. Pop on empty is ignored; push on full is
// accepted only when a pop frees the slot in the same cycle.
module byte_fifo #(
  parameter int DEPTH = 16,
  parameter int W     = 8,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic          pop,
  input  logic [W-1:0]  wdata,
  output logic [W-1:0]  rdata,
  output logic [AW:0]   count,
  output logic          full,
  output logic          empty
);

  logic [DEPTH-1:0][W-1:0] mem;
  logic [AW-1:0]           wp, rp;
  logic                    do_push, do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign do_pop  = pop & ~empty;
  // A pop on a full FIFO frees the slot the simultaneous push needs.
  assign do_push = push & (~full | do_pop);
  assign rdata   = mem[rp];

  // Storage array; contents need no reset since count gates visibility.
  always_ff @(posedge clk) begin
    if (do_push) mem[wp] <= wdata;
  end

  // Pointers and occupancy; count can only move within 0..DEPTH given the gating above.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wp    <= '0;
      rp    <= '0;
      count <= '0;
    end else begin
      if (do_push) wp <= wp + 1'b1;
      if (do_pop)  rp <= rp + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/uart_rx_fifo.sv
// Receive buffer: turns the receiver's valid level into one push per pulse,
// queues bytes, and formats data/status words for CPU polling.
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH = UART_FIFO_DEPTH
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  input  logic        pop,
  input  logic        clr_overrun,
  output logic [31:0] rd_data,
  output logic [31:0] status,
  output logic        empty,
  output logic        full
);

  localparam int AW = $clog2(DEPTH);

  logic          rx_prev;
  logic          push;
  logic          overrun;
  logic          drop;
  logic [7:0]    head;
  logic [AW:0]   count;

  assign push = rx_valid & ~rx_prev;
  // Full implies non-empty, so a coincident pop always frees room.
  assign drop = push & full & ~pop;

  byte_fifo #(.DEPTH(DEPTH), .W(8)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .wdata (rx_data),
    .rdata (head),
    .count (count),
    .full  (full),
    .empty (empty)
  );

  // Edge detector reset high so a valid level held across reset is not taken as a new byte.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) rx_prev <= 1'b1;
    else     rx_prev <= rx_valid;
  end

  // Sticky overrun; a dropping push beats a coincident clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)              overrun <= 1'b0;
    else if (drop)        overrun <= 1'b1;
    else if (clr_overrun) overrun <= 1'b0;
  end

  // Software-visible words, decoded from registered state only.
  always_comb begin
    rd_data = empty ? 32'h0 : {24'h0, head};
    status  = fmt_status(8'(count), empty, full, overrun);
  end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Bench for uart_rx_fifo: directed table, hand sequences, and randomized
// traffic checked against a queue-based reference model.
module tb_uart_rx_fifo;

  localparam int DEPTH = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  rx_data;
  logic        rx_valid, pop, clr_overrun;
  logic [31:0] rd_data, status;
  logic        empty, full;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model state: byte queue, sticky flag, last seen valid level.
  byte unsigned q[$];
  bit           m_ovr;
  bit           m_prev;

  typedef struct {
    logic        rv;
    logic [7:0]  d;
    logic        p;
    logic        c;
    logic [31:0] rd;
    logic [31:0] st;
  } vec_t;

  vec_t tbl[15];

  always #5 clk = ~clk;

  uart_rx_fifo #(.DEPTH(DEPTH)) dut (
    .clk         (clk),
    .rst         (rst),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .pop         (pop),
    .clr_overrun (clr_overrun),
    .rd_data     (rd_data),
    .status      (status),
    .empty       (empty),
    .full        (full)
  );

  function automatic vec_t mk(logic rv, logic [7:0] d, logic p, logic c,
                              logic [31:0] rd, logic [31:0] st);
    vec_t v;
    v.rv = rv; v.d = d; v.p = p; v.c = c; v.rd = rd; v.st = st;
    return v;
  endfunction

  function automatic logic [31:0] m_status();
    return {21'b0, m_ovr, q.size() == DEPTH, q.size() == 0, 8'(q.size())};
  endfunction

  function automatic logic [31:0] m_rd();
    return (q.size() > 0) ? {24'h0, q[0]} : 32'h0;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_ovr  = 1'b0;
    m_prev = 1'b1;
  endtask

  // One clock of the behavioural rules: new byte on a low-to-high valid,
  // pop only when something is stored, drop only when no room is made.
  task automatic model_step(input bit rv, input byte unsigned d, input bit p, input bit c);
    bit psh, popok, drop;
    psh    = rv && !m_prev;
    m_prev = rv;
    popok  = p && (q.size() > 0);
    drop   = psh && (q.size() == DEPTH) && !popok;
    if (popok) void'(q.pop_front());
    if (psh && !drop) q.push_back(d);
    if (drop)   m_ovr = 1'b1;
    else if (c) m_ovr = 1'b0;
  endtask

  task automatic step(input logic rv, input logic [7:0] d, input logic p, input logic c);
    rx_valid    = rv;
    rx_data     = d;
    pop         = p;
    clr_overrun = c;
    @(posedge clk);
    #1;
    model_step(rv, d, p, c);
  endtask

  task automatic step_chk(input logic rv, input logic [7:0] d, input logic p, input logic c);
    step(rv, d, p, c);
    check("rand rd_data", rd_data, m_rd());
    check("rand status", status, m_status());
    check("rand empty/full", {30'b0, full, empty},
          {30'b0, q.size() == DEPTH, q.size() == 0});
  endtask

  task automatic push_byte(input logic [7:0] d);
    step(1'b1, d, 1'b0, 1'b0);
    step(1'b0, d, 1'b0, 1'b0);
  endtask

  initial begin
    // Directed table: valid held through reset, long pulse, empty pop, push+pop on empty.
    tbl[0]  = mk(1, 8'h55, 0, 0, 32'h0,  32'h100);
    tbl[1]  = mk(1, 8'h55, 0, 0, 32'h0,  32'h100);
    tbl[2]  = mk(1, 8'h55, 0, 0, 32'h0,  32'h100);
    tbl[3]  = mk(0, 8'h00, 0, 0, 32'h0,  32'h100);
    tbl[4]  = mk(1, 8'h44, 0, 0, 32'h44, 32'h001);
    tbl[5]  = mk(1, 8'h44, 0, 0, 32'h44, 32'h001);
    tbl[6]  = mk(1, 8'h44, 0, 0, 32'h44, 32'h001);
    tbl[7]  = mk(1, 8'h44, 0, 0, 32'h44, 32'h001);
    tbl[8]  = mk(1, 8'h44, 0, 0, 32'h44, 32'h001);
    tbl[9]  = mk(0, 8'h00, 0, 0, 32'h44, 32'h001);
    tbl[10] = mk(0, 8'h00, 1, 0, 32'h0,  32'h100);
    tbl[11] = mk(0, 8'h00, 1, 0, 32'h0,  32'h100);
    tbl[12] = mk(1, 8'hAA, 1, 0, 32'hAA, 32'h001);
    tbl[13] = mk(0, 8'h00, 0, 0, 32'hAA, 32'h001);
    tbl[14] = mk(0, 8'h00, 1, 0, 32'h0,  32'h100);

    rst = 1'b1; rx_valid = 1'b1; rx_data = 8'h55; pop = 1'b0; clr_overrun = 1'b0;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    check("reset status", status, 32'h100);
    check("reset rd_data", rd_data, 32'h0);
    check("reset empty/full", {30'b0, full, empty}, 32'h1);
    rst = 1'b0;

    foreach (tbl[i]) begin
      step(tbl[i].rv, tbl[i].d, tbl[i].p, tbl[i].c);
      check($sformatf("vec%0d rd_data", i), rd_data, tbl[i].rd);
      check($sformatf("vec%0d status", i), status, tbl[i].st);
    end

    // Fill to full, then one more byte is dropped and flags overrun.
    for (int i = 0; i < DEPTH; i++) push_byte(8'(i));
    check("fill status", status, 32'h210);
    push_byte(8'h4C);
    check("overflow status", status, 32'h610);
    for (int i = 0; i < DEPTH; i++) begin
      check("drain order", rd_data, 32'(i));
      step(1'b0, 8'h00, 1'b1, 1'b0);
    end
    check("drained status", status, 32'h500);
    step(1'b0, 8'h00, 1'b0, 1'b1);
    check("clr_overrun status", status, 32'h100);

    // Push with simultaneous pop while full: no drop, new byte lands last.
    for (int i = 0; i < DEPTH; i++) push_byte(8'(8'h20 + i));
    step(1'b1, 8'h52, 1'b1, 1'b0);
    check("full push+pop status", status, 32'h210);
    step(1'b0, 8'h00, 1'b0, 1'b0);
    for (int i = 1; i < DEPTH; i++) begin
      check("full push+pop order", rd_data, 32'(8'h20 + i));
      step(1'b0, 8'h00, 1'b1, 1'b0);
    end
    check("full push+pop last", rd_data, 32'h52);
    step(1'b0, 8'h00, 1'b1, 1'b0);

    // Drop coinciding with clear: set wins.
    for (int i = 0; i < DEPTH; i++) push_byte(8'(8'h60 + i));
    step(1'b1, 8'h99, 1'b0, 1'b1);
    check("set beats clear", status, 32'h610);
    step(1'b0, 8'h00, 1'b0, 1'b0);
    for (int i = 0; i < DEPTH - 5; i++) step(1'b0, 8'h00, 1'b1, 1'b0);
    check("five entries + ovr", status, 32'h405);

    // Asynchronous reset mid-cycle with valid held high.
    #2;
    rx_valid = 1'b1; rx_data = 8'h66; pop = 1'b0;
    rst = 1'b1;
    #1;
    check("async reset status", status, 32'h100);
    check("async reset rd_data", rd_data, 32'h0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    step(1'b1, 8'h66, 1'b0, 1'b0);
    check("valid held after reset", status, 32'h100);
    step(1'b0, 8'h00, 1'b0, 1'b0);
    step(1'b1, 8'h77, 1'b0, 1'b0);
    check("first byte after reset", rd_data, 32'h77);
    check("first byte status", status, 32'h001);
    step(1'b0, 8'h00, 1'b0, 1'b0);

    // Randomized traffic vs. reference queue; push-heavy so full/wrap/drops occur.
    for (int i = 0; i < 300; i++) begin
      logic rv, p, c;
      rv = ($urandom_range(0, 3) != 0) ? ~m_prev : m_prev;
      p  = (i >= 150) ? ($urandom_range(0, 1) == 1) : ($urandom_range(0, 4) == 0);
      c  = ($urandom_range(0, 15) == 0);
      step_chk(rv, 8'($urandom), p, c);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
